// File: rtl/shared_ocm_pkg.sv
// Shared definitions for the dual-port shared OCM: latency limits, collision
// priority encoding and byte-lane width helper.
package shared_ocm_pkg;

   localparam int RL_MIN = 1;
   localparam int RL_MAX = 2;

   typedef enum logic {
      PRIO_S1 = 1'b0,
      PRIO_S2 = 1'b1
   } prio_e;

   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

   function automatic bit rl_legal(input int rl);
      return (rl >= RL_MIN) && (rl <= RL_MAX);
   endfunction

endpackage

// File: rtl/shared_ocm_ram_core.sv
// Inferred true-dual-port byte-enabled RAM: one-cycle registered read,
// mixed-port read of a location being written returns the old word.
module shared_ocm_ram_core
   import shared_ocm_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 7,
   parameter     INIT_FILE = ""
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          we_a,
   input  logic                          re_a,
   input  logic [ADDR_W-1:0]             addr_a,
   input  logic [be_width(DATA_W)-1:0]   be_a,
   input  logic [DATA_W-1:0]             wdata_a,
   output logic [DATA_W-1:0]             q_a,
   input  logic                          we_b,
   input  logic                          re_b,
   input  logic [ADDR_W-1:0]             addr_b,
   input  logic [be_width(DATA_W)-1:0]   be_b,
   input  logic [DATA_W-1:0]             wdata_b,
   output logic [DATA_W-1:0]             q_b
);

   localparam int BE_W  = be_width(DATA_W);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   // Same-address double writes never reach here: the top arbitrates them.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++) begin
         if (we_a && be_a[i]) mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
         if (we_b && be_b[i]) mem[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
      end
   end

   // Read registers sample mem before this edge's writes land (old data).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_a <= '0;
         q_b <= '0;
      end else begin
         if (re_a) q_a <= mem[addr_a];
         if (re_b) q_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/shared_ocm_dp.sv
// Dual Avalon-MM slave shared on-chip memory: write-collision arbitration with
// rotating priority, per-port waitrequest, and read-valid pipelines.
module shared_ocm_dp
   import shared_ocm_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 7,
   parameter int READ_LATENCY = 1,
   parameter bit PRIORITY     = 1'b0,
   parameter     INIT_FILE    = ""
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        reset_req,
   input  logic [ADDR_W-1:0]           address,
   input  logic [ADDR_W-1:0]           address2,
   input  logic [be_width(DATA_W)-1:0] byteenable,
   input  logic [be_width(DATA_W)-1:0] byteenable2,
   input  logic                        chipselect,
   input  logic                        chipselect2,
   input  logic                        read,
   input  logic                        read2,
   input  logic                        write,
   input  logic                        write2,
   input  logic                        clken,
   input  logic                        clken2,
   input  logic [DATA_W-1:0]           writedata,
   input  logic [DATA_W-1:0]           writedata2,
   output logic                        waitrequest,
   output logic                        waitrequest2,
   output logic [DATA_W-1:0]           readdata,
   output logic [DATA_W-1:0]           readdata2,
   output logic                        readdatavalid,
   output logic                        readdatavalid2
);

   // Out-of-range latency settings fall back to the single-cycle path.
   localparam int RL = rl_legal(READ_LATENCY) ? READ_LATENCY : RL_MIN;

   prio_e prio;

   logic wr_req1, wr_req2, rd_req1, rd_req2;
   logic stall1, stall2, collide, lose1, lose2;
   logic we1, we2, re1, re2;
   logic [DATA_W-1:0] q1, q2;

   // Read+write together is treated as a write only.
   assign wr_req1 = chipselect  & write;
   assign wr_req2 = chipselect2 & write2;
   assign rd_req1 = chipselect  & read  & ~write;
   assign rd_req2 = chipselect2 & read2 & ~write2;

   assign stall1 = reset | reset_req | ~clken;
   assign stall2 = reset | reset_req | ~clken2;

   // Only writes that would otherwise be accepted can collide.
   assign collide = wr_req1 & wr_req2 & ~stall1 & ~stall2 & (address == address2);
   assign lose1   = collide & (prio == PRIO_S2);
   assign lose2   = collide & (prio == PRIO_S1);

   assign waitrequest  = stall1 | lose1;
   assign waitrequest2 = stall2 | lose2;

   assign we1 = wr_req1 & ~waitrequest;
   assign we2 = wr_req2 & ~waitrequest2;
   assign re1 = rd_req1 & ~waitrequest;
   assign re2 = rd_req2 & ~waitrequest2;

   // Loser of each collision owns the next one, so neither port starves.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        prio <= prio_e'(PRIORITY);
      else if (collide) prio <= (prio == PRIO_S1) ? PRIO_S2 : PRIO_S1;
   end

   shared_ocm_ram_core #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we_a    (we1),
      .re_a    (re1),
      .addr_a  (address),
      .be_a    (byteenable),
      .wdata_a (writedata),
      .q_a     (q1),
      .we_b    (we2),
      .re_b    (re2),
      .addr_b  (address2),
      .be_b    (byteenable2),
      .wdata_b (writedata2),
      .q_b     (q2)
   );

   if (RL == 2) begin : g_lat2
      logic              v1_s0, v1_s1, v2_s0, v2_s1;
      logic [DATA_W-1:0] rdata1_q, rdata2_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            v1_s0    <= 1'b0;
            v1_s1    <= 1'b0;
            v2_s0    <= 1'b0;
            v2_s1    <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
         end else begin
            v1_s0 <= re1;
            v1_s1 <= v1_s0;
            v2_s0 <= re2;
            v2_s1 <= v2_s0;
            if (v1_s0) rdata1_q <= q1;
            if (v2_s0) rdata2_q <= q2;
         end
      end

      assign readdatavalid  = v1_s1;
      assign readdatavalid2 = v2_s1;
      assign readdata       = rdata1_q;
      assign readdata2      = rdata2_q;
   end else begin : g_lat1
      logic v1_s0, v2_s0;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            v1_s0 <= 1'b0;
            v2_s0 <= 1'b0;
         end else begin
            v1_s0 <= re1;
            v2_s0 <= re2;
         end
      end

      // RAM read registers only load on accepted reads, so they hold.
      assign readdatavalid  = v1_s0;
      assign readdatavalid2 = v2_s0;
      assign readdata       = q1;
      assign readdata2      = q2;
   end

endmodule

// File: tb/tb_shared_ocm_dp.sv
// Directed bench for shared_ocm_dp: one instance at read latency 1 (index 0)
// and one at latency 2 (index 1), driven by the same stimulus.
module tb_shared_ocm_dp;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        reset_req;
   logic [6:0]  a1, a2;
   logic [3:0]  be1, be2;
   logic        cs1, cs2, r1, r2, w1, w2, ck1, ck2;
   logic [31:0] wd1, wd2;

   logic [1:0]  wq1, wq2, rv1, rv2;
   logic [31:0] rd1 [2];
   logic [31:0] rd2 [2];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      shared_ocm_dp #(
         .DATA_W       (32),
         .ADDR_W       (7),
         .READ_LATENCY (g + 1),
         .PRIORITY     (1'b0),
         .INIT_FILE    ("")
      ) dut (
         .clk            (clk),
         .reset          (reset),
         .reset_req      (reset_req),
         .address        (a1),
         .address2       (a2),
         .byteenable     (be1),
         .byteenable2    (be2),
         .chipselect     (cs1),
         .chipselect2    (cs2),
         .read           (r1),
         .read2          (r2),
         .write          (w1),
         .write2         (w2),
         .clken          (ck1),
         .clken2         (ck2),
         .writedata      (wd1),
         .writedata2     (wd2),
         .waitrequest    (wq1[g]),
         .waitrequest2   (wq2[g]),
         .readdata       (rd1[g]),
         .readdata2      (rd2[g]),
         .readdatavalid  (rv1[g]),
         .readdatavalid2 (rv2[g])
      );
   end

   typedef struct {
      string      nm;
      logic       rr, c1, c2;
      logic       s1, rd1, wr1;
      logic [6:0] ad1;
      logic       s2, rd2, wr2;
      logic [6:0] ad2;
      logic       ew1, ew2;
   } vec_t;

   vec_t vt [12];

   function automatic vec_t mk(input string nm, input logic rr, c1, c2,
                               input logic s1, rd1, wr1, input logic [6:0] ad1,
                               input logic s2, rd2, wr2, input logic [6:0] ad2,
                               input logic ew1, ew2);
      vec_t v;
      v.nm = nm; v.rr = rr; v.c1 = c1; v.c2 = c2;
      v.s1 = s1; v.rd1 = rd1; v.wr1 = wr1; v.ad1 = ad1;
      v.s2 = s2; v.rd2 = rd2; v.wr2 = wr2; v.ad2 = ad2;
      v.ew1 = ew1; v.ew2 = ew2;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset_req = 1'b0;
      ck1 = 1'b1; ck2 = 1'b1;
      cs1 = 1'b0; r1 = 1'b0; w1 = 1'b0; a1 = '0; wd1 = '0; be1 = '0;
      cs2 = 1'b0; r2 = 1'b0; w2 = 1'b0; a2 = '0; wd2 = '0; be2 = '0;
   endtask

   task automatic set_cmd(input int p, input logic cs, input logic r, input logic w,
                          input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
      if (p == 1) begin
         cs1 = cs; r1 = r; w1 = w; a1 = a; wd1 = d; be1 = be;
      end else begin
         cs2 = cs; r2 = r; w2 = w; a2 = a; wd2 = d; be2 = be;
      end
   endtask

   task automatic chk_wait(input string nm, input logic e1, input logic e2);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s waitrequest rl%0d", nm, d + 1), wq1[d], e1);
         chk($sformatf("%s waitrequest2 rl%0d", nm, d + 1), wq2[d], e2);
      end
   endtask

   task automatic chk_rd(input string nm, input int p, input int d,
                         input logic ev, input logic [31:0] ed);
      logic        v;
      logic [31:0] q;
      v = (p == 1) ? rv1[d] : rv2[d];
      q = (p == 1) ? rd1[d] : rd2[d];
      chk($sformatf("%s valid p%0d rl%0d", nm, p, d + 1), v, ev);
      if (ev) chk($sformatf("%s data p%0d rl%0d", nm, p, d + 1), q, ed);
   endtask

   task automatic write_go(input string nm, input int p, input logic [6:0] a,
                           input logic [31:0] d, input logic [3:0] be);
      set_cmd(p, 1'b1, 1'b0, 1'b1, a, d, be);
      #1;
      for (int k = 0; k < 2; k++)
         chk($sformatf("%s accept rl%0d", nm, k + 1), (p == 1) ? wq1[k] : wq2[k], 1'b0);
      tick();
      set_cmd(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // Read on port p; checks the latency-1 pulse at the accept edge and the
   // latency-2 pulse exactly one edge later.
   task automatic read_chk(input string nm, input int p, input logic [6:0] a,
                           input logic [31:0] exp);
      set_cmd(p, 1'b1, 1'b1, 1'b0, a, '0, '0);
      #1;
      for (int k = 0; k < 2; k++)
         chk($sformatf("%s accept rl%0d", nm, k + 1), (p == 1) ? wq1[k] : wq2[k], 1'b0);
      tick();
      set_cmd(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      chk_rd({nm, " e0"}, p, 0, 1'b1, exp);
      chk_rd({nm, " e0"}, p, 1, 1'b0, '0);
      tick();
      chk_rd({nm, " e1"}, p, 0, 1'b0, '0);
      chk_rd({nm, " e1"}, p, 1, 1'b1, exp);
      chk($sformatf("%s hold p%0d rl1", nm, p), (p == 1) ? rd1[0] : rd2[0], exp);
   endtask

   logic [31:0] sd [4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1'b1;
      tick();
      chk_wait("reset", 1'b1, 1'b1);
      for (int d = 0; d < 2; d++) begin
         chk_rd("reset", 1, d, 1'b0, '0);
         chk_rd("reset", 2, d, 1'b0, '0);
         chk($sformatf("reset readdata rl%0d", d + 1), rd1[d], 32'h0);
         chk($sformatf("reset readdata2 rl%0d", d + 1), rd2[d], 32'h0);
      end
      tick();
      reset = 1'b0;
      tick();

      // Waitrequest decode with prio at its reset value (s1 wins).
      //             name          rr c1 c2 s1 r1 w1 a1  s2 r2 w2 a2  ew1 ew2
      vt[0]  = mk("idle",        0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
      vt[1]  = mk("rd_rd_same",  0, 1, 1, 1, 1, 0, 4,  1, 1, 0, 4,  0, 0);
      vt[2]  = mk("wr_wr_diff",  0, 1, 1, 1, 0, 1, 4,  1, 0, 1, 5,  0, 0);
      vt[3]  = mk("wr_rd_same",  0, 1, 1, 1, 0, 1, 4,  1, 1, 0, 4,  0, 0);
      vt[4]  = mk("wr_wr_same",  0, 1, 1, 1, 0, 1, 4,  1, 0, 1, 4,  0, 1);
      vt[5]  = mk("s1_clken_lo", 0, 0, 1, 1, 0, 1, 4,  1, 0, 1, 4,  1, 0);
      vt[6]  = mk("s2_clken_lo", 0, 1, 0, 1, 0, 1, 4,  1, 0, 1, 4,  0, 1);
      vt[7]  = mk("reset_req",   1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1);
      vt[8]  = mk("rw_rw_same",  0, 1, 1, 1, 1, 1, 4,  1, 1, 1, 4,  0, 1);
      vt[9]  = mk("cs2_low",     0, 1, 1, 1, 0, 1, 4,  0, 0, 1, 4,  0, 0);
      vt[10] = mk("rd_wr_same",  0, 1, 1, 1, 1, 0, 4,  1, 0, 1, 4,  0, 0);
      vt[11] = mk("clken2_only", 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1);

      for (int i = 0; i < 12; i++) begin
         reset_req = vt[i].rr; ck1 = vt[i].c1; ck2 = vt[i].c2;
         cs1 = vt[i].s1; r1 = vt[i].rd1; w1 = vt[i].wr1; a1 = vt[i].ad1;
         cs2 = vt[i].s2; r2 = vt[i].rd2; w2 = vt[i].wr2; a2 = vt[i].ad2;
         #1;
         chk_wait(vt[i].nm, vt[i].ew1, vt[i].ew2);
         idle();
         tick();
      end

      // Write on s1, read back on s2 one cycle later.
      write_go("t1 wr", 1, 7'd5, 32'hDEADBEEF, 4'hF);
      read_chk("t1 rd", 2, 7'd5, 32'hDEADBEEF);

      // Same-address collision, then an identical one won by s2.
      set_cmd(1, 1'b1, 1'b0, 1'b1, 7'd9, 32'h11111111, 4'hF);
      set_cmd(2, 1'b1, 1'b0, 1'b1, 7'd9, 32'h22222222, 4'hF);
      #1;
      chk_wait("col1", 1'b0, 1'b1);
      tick();
      set_cmd(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      chk_wait("col1 retry", 1'b0, 1'b0);
      tick();
      set_cmd(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      read_chk("col1 rd", 1, 7'd9, 32'h22222222);

      set_cmd(1, 1'b1, 1'b0, 1'b1, 7'd9, 32'h11111111, 4'hF);
      set_cmd(2, 1'b1, 1'b0, 1'b1, 7'd9, 32'h22222222, 4'hF);
      #1;
      chk_wait("col2", 1'b1, 1'b0);
      tick();
      set_cmd(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      chk_wait("col2 retry", 1'b0, 1'b0);
      tick();
      set_cmd(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      read_chk("col2 rd", 2, 7'd9, 32'h11111111);

      // Partial byte enables, then an all-lanes-off write.
      write_go("be clr", 1, 7'd3, 32'h00000000, 4'hF);
      write_go("be 5", 1, 7'd3, 32'hAABBCCDD, 4'h5);
      read_chk("be rd", 2, 7'd3, 32'h00BB00DD);
      write_go("be 0", 2, 7'd3, 32'hFFFFFFFF, 4'h0);
      read_chk("be0 rd", 1, 7'd3, 32'h00BB00DD);

      // s2 streams four reads while s1 clken is low for the first two.
      for (int i = 0; i < 4; i++) begin
         sd[i] = 32'hC0DE0000 + 32'(i * 32'h111);
         write_go("st pre", 1, 7'(i), sd[i], 4'hF);
      end
      for (int j = 0; j < 6; j++) begin
         if (j < 4) set_cmd(2, 1'b1, 1'b1, 1'b0, 7'(j), '0, '0);
         else       set_cmd(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
         ck1 = (j < 2) ? 1'b0 : 1'b1;
         #1;
         if (j < 4) chk_wait($sformatf("st c%0d", j), (j < 2), 1'b0);
         tick();
         chk_rd($sformatf("st c%0d", j), 2, 0, (j < 4), (j < 4) ? sd[j % 4] : '0);
         chk_rd($sformatf("st c%0d", j), 2, 1, (j >= 1 && j <= 4), (j >= 1 && j <= 4) ? sd[(j + 3) % 4] : '0);
      end
      ck1 = 1'b1;

      // Mixed-port read and write to the same word returns old data.
      write_go("mx pre", 1, 7'd7, 32'h1, 4'hF);
      set_cmd(1, 1'b1, 1'b0, 1'b1, 7'd7, 32'h5, 4'hF);
      set_cmd(2, 1'b1, 1'b1, 1'b0, 7'd7, '0, '0);
      #1;
      chk_wait("mx", 1'b0, 1'b0);
      tick();
      set_cmd(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      set_cmd(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      chk_rd("mx e0", 2, 0, 1'b1, 32'h1);
      tick();
      chk_rd("mx e1", 2, 1, 1'b1, 32'h1);
      read_chk("mx new", 2, 7'd7, 32'h5);

      // Move prio to s2, then reset in the middle of an s2 read.
      set_cmd(1, 1'b1, 1'b0, 1'b1, 7'd20, 32'hA, 4'hF);
      set_cmd(2, 1'b1, 1'b0, 1'b1, 7'd20, 32'hB, 4'hF);
      #1;
      chk_wait("rst col", 1'b0, 1'b1);
      tick();
      set_cmd(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      set_cmd(2, 1'b1, 1'b1, 1'b0, 7'd5, '0, '0);
      tick();
      set_cmd(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      reset = 1'b1;
      #1;
      chk_wait("rst mid", 1'b1, 1'b1);
      for (int d = 0; d < 2; d++) begin
         chk_rd("rst mid", 2, d, 1'b0, '0);
         chk($sformatf("rst mid readdata2 rl%0d", d + 1), rd2[d], 32'h0);
         chk($sformatf("rst mid readdata rl%0d", d + 1), rd1[d], 32'h0);
      end
      tick();
      chk_rd("rst hold", 2, 1, 1'b0, '0);
      reset = 1'b0;
      tick();
      chk_rd("rst post", 2, 0, 1'b0, '0);
      chk_rd("rst post", 2, 1, 1'b0, '0);

      // prio back at its reset value: s1 wins again.
      set_cmd(1, 1'b1, 1'b0, 1'b1, 7'd20, 32'hA, 4'hF);
      set_cmd(2, 1'b1, 1'b0, 1'b1, 7'd20, 32'hB, 4'hF);
      #1;
      chk_wait("rst prio", 1'b0, 1'b1);
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shared_ocm_dp.md
# shared_ocm_dp

Parametrised true-dual-port shared on-chip memory with two independent Avalon-MM slave ports (s1, s2) on one clock. It is the successor of the fixed 128 x 32 shared OCM and adds parametrised width and depth, selectable read latency with `readdatavalid`, and `waitrequest`-based arbitration of same-address write collisions with starvation-free priority rotation. It sits between two bus masters, typically two CPUs or a CPU and a DMA, as their shared mailbox and buffer RAM.

## Interface
- DATA_W, 32: word width; a multiple of 8.
- ADDR_W, 7: word address width; depth = 2^ADDR_W.
- READ_LATENCY, 1: 1 or 2; 2 adds an output register stage.
- PRIORITY, 0: initial collision winner; 0 = s1, 1 = s2.
- INIT_FILE, "": hex init image; empty means all words zero.
- clk  in  1  single clock for both ports
- reset  in  1  asynchronous, active-high reset
- reset_req  in  1  quiesce request; blocks acceptance of new accesses
- address / address2  in  ADDR_W  word address, s1 / s2
- byteenable / byteenable2  in  DATA_W/8  write byte lanes
- chipselect / chipselect2, read / read2, write / write2  in  1  Avalon command
- clken / clken2  in  1  per-port enable; low stalls the port
- writedata / writedata2  in  DATA_W  write data
- waitrequest / waitrequest2  out  1  command not accepted this cycle
- readdata / readdata2  out  DATA_W  read data
- readdatavalid / readdatavalid2  out  1  readdata valid this cycle

## Operation
- A port request is `chipselect & (read|write)`. It is accepted at a rising edge when the request is high and the port's waitrequest is low.
- If `read` and `write` are both high, the access is a write and no readdatavalid is produced.
- Port waitrequest is combinational and is 1 when any of these holds:
  - reset is high;
  - reset_req is high;
  - the port's clken is low;
  - the port loses a collision.
- Collision: both ports issue accepted-eligible writes to the same address in the same cycle.
  - The winner is given by the `prio` state bit: 0 = s1, 1 = s2. The loser sees waitrequest=1 for that cycle.
  - After every collision, `prio` flips to the loser. The loser therefore wins the next collision and cannot starve.
  - The other cases are not collisions and raise no waitrequest: read/read to any address, and read/write or write/write to different addresses.
- Mixed-port read and write to the same address in the same cycle: the read returns the old data.
- Write with byteenable = 0: the write is accepted and memory is unchanged.
- Each port has a valid shift pipeline of depth READ_LATENCY. It carries the accept flag of each read.
- Asserting reset_req or dropping clken does not cancel in-flight reads: they complete at their normal latency.
- Only the `prio` state bit and the pipeline registers are reset. Memory contents are not reset.

## Timing
- Reset values:
  - readdatavalid and readdatavalid2 = 0;
  - readdata and readdata2 = 0;
  - prio = PRIORITY;
  - waitrequest and waitrequest2 = 1 while reset is high.
- Read accepted at edge T: readdatavalid is high in the cycle after edge T+READ_LATENCY−1, i.e. sampled at edge T+READ_LATENCY. It is a one-cycle pulse per read.
- Back-to-back reads: one accepted per cycle per port, with no bubbles.
- readdata holds its last value when readdatavalid = 0.
- Write accepted at edge T: the data is visible to a read on either port accepted at edge T+1 or later.
- Asynchronous reset asserted mid-read: pipelines clear immediately and no readdatavalid is emitted for that read.

## Structure
- Package `shared_ocm_pkg`: legal READ_LATENCY values, the PRIORITY encoding constants, and a function `be_width(DATA_W)`.
- Sub-module `shared_ocm_ram_core`: an inferred true-dual-port byte-enabled RAM with registered address, one-cycle read and old-data mixed-port behaviour.
- The top level holds the collision compare, the `prio` bit, the waitrequest logic, the valid pipelines and the optional output registers.

## Test plan
- Reset, then s1 writes 0xDEADBEEF to address 5 with byteenable=0xF, then s2 reads address 5 one cycle later → readdata2=0xDEADBEEF, with readdatavalid2 after exactly READ_LATENCY cycles (run at both 1 and 2).
- Both ports write address 9 in the same cycle (s1 0x11111111, s2 0x22222222) with PRIORITY=0 →
  - s2 sees waitrequest2=1 for one cycle, then is accepted;
  - a final read of address 9 returns 0x22222222;
  - a second identical collision is won by s2.
- s1 writes 0xAABBCCDD to address 3 with byteenable=0x5 over an initial 0x00000000 → a read returns 0x00BB00DD.
- s2 streams 4 back-to-back reads of addresses 0–3 while s1 lowers clken for 2 cycles → s1 waitrequest=1 for those 2 cycles, and s2 gets 4 consecutive readdatavalid pulses with correct data.
- Same-cycle s1 write of 0x5 and s2 read at address 7, which holds 0x1 → readdata2=0x1; a subsequent read returns 0x5.
- Assert reset between acceptance and readdatavalid → no valid pulse; outputs are 0; prio returns to PRIORITY.
